// File: rtl/nic_row_ctrl_if.sv
// Host and NIC-row signal bundle for nic_row_ctrl.
// The master modport is the controller's view; slave is the host/NIC side.
interface nic_row_ctrl_if #(
  parameter int PACKET_WIDTH = 64
);
  logic                    tx_valid;
  logic [1:0]              tx_dest;
  logic [PACKET_WIDTH-1:0] tx_data;
  logic                    tx_ready;

  logic                    rx_valid;
  logic                    rx_ready;
  logic [1:0]              rx_src;
  logic [PACKET_WIDTH-1:0] rx_data;

  logic [1:0]              nic_addr;
  logic [PACKET_WIDTH-1:0] nic_wdata;
  logic [3:0]              nicEn;
  logic                    nicEnWR;
  logic [PACKET_WIDTH-1:0] nic_rdata_0;
  logic [PACKET_WIDTH-1:0] nic_rdata_1;
  logic [PACKET_WIDTH-1:0] nic_rdata_2;
  logic [PACKET_WIDTH-1:0] nic_rdata_3;

  logic [15:0]             tx_stall_cnt;

  modport master (
    input  tx_valid, tx_dest, tx_data, rx_ready,
    input  nic_rdata_0, nic_rdata_1, nic_rdata_2, nic_rdata_3,
    output tx_ready, rx_valid, rx_src, rx_data,
    output nic_addr, nic_wdata, nicEn, nicEnWR, tx_stall_cnt
  );

  modport slave (
    output tx_valid, tx_dest, tx_data, rx_ready,
    output nic_rdata_0, nic_rdata_1, nic_rdata_2, nic_rdata_3,
    input  tx_ready, rx_valid, rx_src, rx_data,
    input  nic_addr, nic_wdata, nicEn, nicEnWR, tx_stall_cnt
  );
endinterface

// File: rtl/nic_row_ctrl.sv
// Row controller sharing one register bus across four NICs: injects host packets
// into NIC output buffers and round-robin polls NIC input buffers back to the host.
//   state  | meaning
//   IDLE   | pick TX or RX turn, alternating under contention
//   TX_CHK | read output status of NIC tx_dest
//   TX_WR  | write tx_data into NIC tx_dest output buffer, tx_ready strobe
//   RX_CHK | read input status of NIC rr_ptr
//   RX_RD  | read input buffer of NIC rr_ptr into rx_data
//   RX_OUT | present packet to host until rx_ready
module nic_row_ctrl #(
  parameter int PACKET_WIDTH = 64
) (
  input  logic           clk,
  input  logic           reset,
  nic_row_ctrl_if.master bus
);

  localparam logic [1:0] ADDR_IN_BUF  = 2'b00;
  localparam logic [1:0] ADDR_IN_STS  = 2'b01;
  localparam logic [1:0] ADDR_OUT_BUF = 2'b10;
  localparam logic [1:0] ADDR_OUT_STS = 2'b11;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    TX_CHK = 3'd1,
    TX_WR  = 3'd2,
    RX_CHK = 3'd3,
    RX_RD  = 3'd4,
    RX_OUT = 3'd5
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [1:0]              r_rr_ptr;
  logic                    r_last_tx;
  logic [15:0]             r_stall_cnt;
  logic [PACKET_WIDTH-1:0] r_rx_data;
  logic [1:0]              r_rx_src;

  logic                    w_go_tx;
  logic                    w_nic_en;
  logic [1:0]              w_nic_sel;
  logic                    w_nic_wr;
  logic [1:0]              w_nic_addr;
  logic [PACKET_WIDTH-1:0] w_nic_wdata;
  logic [PACKET_WIDTH-1:0] w_rdata;
  logic                    w_tx_ready;
  logic                    w_rx_valid;
  logic                    w_stall_inc;
  logic                    w_rr_adv;
  logic                    w_rx_load;

  always_comb begin
    w_rdata = '0;
    case (w_nic_sel)
      2'd0:    w_rdata = bus.nic_rdata_0;
      2'd1:    w_rdata = bus.nic_rdata_1;
      2'd2:    w_rdata = bus.nic_rdata_2;
      default: w_rdata = bus.nic_rdata_3;
    endcase
  end

  // Receive polling is always pending, so a waiting TX wins only on alternate turns.
  assign w_go_tx = bus.tx_valid && !r_last_tx;

  always_comb begin
    w_state_nxt = r_state;
    w_nic_en    = 1'b0;
    w_nic_sel   = 2'd0;
    w_nic_wr    = 1'b0;
    w_nic_addr  = 2'b00;
    w_nic_wdata = '0;
    w_tx_ready  = 1'b0;
    w_rx_valid  = 1'b0;
    w_stall_inc = 1'b0;
    w_rr_adv    = 1'b0;
    w_rx_load   = 1'b0;
    case (r_state)
      IDLE: begin
        w_state_nxt = w_go_tx ? TX_CHK : RX_CHK;
      end
      TX_CHK: begin
        w_nic_en   = 1'b1;
        w_nic_sel  = bus.tx_dest;
        w_nic_addr = ADDR_OUT_STS;
        if (!bus.tx_valid) begin
          w_state_nxt = IDLE;
        end else if (w_rdata[0]) begin
          w_stall_inc = 1'b1;
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = TX_WR;
        end
      end
      TX_WR: begin
        w_nic_en    = 1'b1;
        w_nic_sel   = bus.tx_dest;
        w_nic_wr    = 1'b1;
        w_nic_addr  = ADDR_OUT_BUF;
        w_nic_wdata = bus.tx_data;
        w_tx_ready  = 1'b1;
        w_state_nxt = IDLE;
      end
      RX_CHK: begin
        w_nic_en   = 1'b1;
        w_nic_sel  = r_rr_ptr;
        w_nic_addr = ADDR_IN_STS;
        if (w_rdata[0]) begin
          w_state_nxt = RX_RD;
        end else begin
          w_rr_adv    = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      RX_RD: begin
        w_nic_en    = 1'b1;
        w_nic_sel   = r_rr_ptr;
        w_nic_addr  = ADDR_IN_BUF;
        w_rx_load   = 1'b1;
        w_state_nxt = RX_OUT;
      end
      RX_OUT: begin
        w_rx_valid = 1'b1;
        if (bus.rx_ready) begin
          w_rr_adv    = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_rr_ptr    <= 2'd0;
      r_last_tx   <= 1'b0;
      r_stall_cnt <= 16'd0;
      r_rx_data   <= '0;
      r_rx_src    <= 2'd0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == IDLE) begin
        r_last_tx <= ~r_last_tx;
      end
      if (w_rr_adv) begin
        r_rr_ptr <= r_rr_ptr + 2'd1;
      end
      if (w_stall_inc && (r_stall_cnt != 16'hFFFF)) begin
        r_stall_cnt <= r_stall_cnt + 16'd1;
      end
      if (w_rx_load) begin
        r_rx_data <= w_rdata;
        r_rx_src  <= r_rr_ptr;
      end
    end
  end

  assign bus.nicEn        = w_nic_en ? (4'b0001 << w_nic_sel) : 4'b0000;
  assign bus.nicEnWR      = w_nic_wr;
  assign bus.nic_addr     = w_nic_addr;
  assign bus.nic_wdata    = w_nic_wdata;
  assign bus.tx_ready     = w_tx_ready;
  assign bus.rx_valid     = w_rx_valid;
  assign bus.rx_data      = r_rx_data;
  assign bus.rx_src       = r_rx_src;
  assign bus.tx_stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_nic_row_ctrl.sv
// Directed bench for nic_row_ctrl with a behavioural four-NIC row and bus monitor.
module tb_nic_row_ctrl;

  logic clk;
  logic reset;

  nic_row_ctrl_if #(.PACKET_WIDTH(64)) bus ();

  nic_row_ctrl #(.PACKET_WIDTH(64)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_fail;

  logic [3:0]  in_full;
  logic [3:0]  out_full;
  logic [63:0] in_data [4];
  int          wr_cnt [4];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] nic_resp(input logic en, input logic wr, input logic [1:0] a,
                                           input logic inf, input logic outf, input logic [63:0] d);
    logic [63:0] r;
    r = '0;
    if (en && !wr) begin
      case (a)
        2'b00:   r = d;
        2'b01:   r = {63'd0, inf};
        2'b11:   r = {63'd0, outf};
        default: r = '0;
      endcase
    end
    return r;
  endfunction

  function automatic int idx_of(input logic [3:0] e);
    int r;
    r = 0;
    for (int i = 0; i < 4; i++) if (e[i]) r = i;
    return r;
  endfunction

  always_comb begin
    bus.nic_rdata_0 = nic_resp(bus.nicEn[0], bus.nicEnWR, bus.nic_addr, in_full[0], out_full[0], in_data[0]);
    bus.nic_rdata_1 = nic_resp(bus.nicEn[1], bus.nicEnWR, bus.nic_addr, in_full[1], out_full[1], in_data[1]);
    bus.nic_rdata_2 = nic_resp(bus.nicEn[2], bus.nicEnWR, bus.nic_addr, in_full[2], out_full[2], in_data[2]);
    bus.nic_rdata_3 = nic_resp(bus.nicEn[3], bus.nicEnWR, bus.nic_addr, in_full[3], out_full[3], in_data[3]);
  end

  // Bus-level invariants, sampled every falling edge outside reset.
  always @(negedge clk) begin
    if (!reset) begin
      chk("onehot", {63'd0, $onehot0(bus.nicEn)}, 64'd1);
      if (bus.nicEn == 4'b0000) begin
        chk("idle_ctl", {61'd0, bus.nic_addr, bus.nicEnWR}, 64'd0);
        chk("idle_wdata", bus.nic_wdata, 64'd0);
      end else if (bus.nicEnWR) begin
        wr_cnt[idx_of(bus.nicEn)]++;
        chk("wr_to_full", {63'd0, out_full[idx_of(bus.nicEn)]}, 64'd0);
      end
      if (bus.tx_ready) chk("txrdy_wr", {61'd0, bus.nicEnWR, bus.nic_addr}, 64'd6);
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_nicEn"}, {60'd0, bus.nicEn}, 64'd0);
    chk({tag, "_ctl"}, {61'd0, bus.nic_addr, bus.nicEnWR}, 64'd0);
    chk({tag, "_wdata"}, bus.nic_wdata, 64'd0);
    chk({tag, "_txrdy"}, {63'd0, bus.tx_ready}, 64'd0);
    chk({tag, "_rxv"}, {63'd0, bus.rx_valid}, 64'd0);
    chk({tag, "_rxsrc"}, {62'd0, bus.rx_src}, 64'd0);
    chk({tag, "_rxdata"}, bus.rx_data, 64'd0);
    chk({tag, "_stall"}, {48'd0, bus.tx_stall_cnt}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        timed_out;
    int          rej;
    int          wr_before;
    int          got;
    logic [1:0]  got_src [2];
    logic [63:0] got_data [2];
    int          clr_idx;
    logic        clr;
    logic        svc, prev_svc, have_prev;
    int          n_tx, n_rx, n_rxv;

    n_checks = 0;
    n_fail   = 0;
    for (int i = 0; i < 4; i++) begin
      in_data[i] = '0;
      wr_cnt[i]  = 0;
    end
    in_full      = 4'b0000;
    out_full     = 4'b0000;
    bus.tx_valid = 1'b0;
    bus.tx_dest  = 2'd0;
    bus.tx_data  = '0;
    bus.rx_ready = 1'b0;
    reset        = 1'b1;

    #12;
    chk_reset_outputs("por");

    // TX to empty NIC2
    @(negedge clk);
    reset        = 1'b0;
    bus.tx_valid = 1'b1;
    bus.tx_dest  = 2'd2;
    bus.tx_data  = 64'hA5A5_0000_0000_0001;
    @(negedge clk);
    chk("txchk_en", {60'd0, bus.nicEn}, 64'h4);
    chk("txchk_ctl", {61'd0, bus.nic_addr, bus.nicEnWR}, 64'd6);
    chk("txchk_rdy", {63'd0, bus.tx_ready}, 64'd0);
    @(negedge clk);
    chk("txwr_en", {60'd0, bus.nicEn}, 64'h4);
    chk("txwr_ctl", {61'd0, bus.nic_addr, bus.nicEnWR}, 64'd5);
    chk("txwr_wdata", bus.nic_wdata, 64'hA5A5_0000_0000_0001);
    chk("txwr_rdy", {63'd0, bus.tx_ready}, 64'd1);
    bus.tx_valid = 1'b0;
    @(negedge clk);
    chk("tx_after_rdy", {63'd0, bus.tx_ready}, 64'd0);
    chk("tx_wr_count2", wr_cnt[2], 1);

    // TX to NIC1 rejected three times, then accepted
    repeat (4) @(negedge clk);
    out_full[1]  = 1'b1;
    wr_before    = wr_cnt[1];
    rej          = 0;
    timed_out    = 1'b1;
    bus.tx_dest  = 2'd1;
    bus.tx_data  = 64'h0000_B0B0_1234_5678;
    bus.tx_valid = 1'b1;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (bus.tx_ready) begin
        timed_out    = 1'b0;
        bus.tx_valid = 1'b0;
        break;
      end
      if (bus.nicEn == 4'b0010 && bus.nic_addr == 2'b11 && !bus.nicEnWR && out_full[1]) begin
        rej++;
        if (rej == 3) begin
          @(posedge clk);
          #1 out_full[1] = 1'b0;
        end
      end
    end
    chk("full_timeout", {63'd0, timed_out}, 64'd0);
    repeat (5) @(negedge clk);
    chk("full_rejects", rej, 3);
    chk("full_stall", {48'd0, bus.tx_stall_cnt}, 64'd3);
    chk("full_one_wr", wr_cnt[1] - wr_before, 1);

    // RX round-robin from reset: NIC0 then NIC3, then wrap to NIC0
    reset = 1'b1;
    #1;
    chk_reset_outputs("rst2");
    in_full      = 4'b1001;
    in_data[0]   = 64'h11;
    in_data[3]   = 64'h33;
    bus.rx_ready = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    got   = 0;
    for (int c = 0; c < 100 && got < 2; c++) begin
      @(negedge clk);
      clr = 1'b0;
      if (bus.nicEn != 4'b0000 && bus.nic_addr == 2'b00 && !bus.nicEnWR) begin
        clr     = 1'b1;
        clr_idx = idx_of(bus.nicEn);
      end
      if (bus.rx_valid && bus.rx_ready) begin
        got_src[got]  = bus.rx_src;
        got_data[got] = bus.rx_data;
        got++;
      end
      if (clr) begin
        @(posedge clk);
        #1 in_full[clr_idx] = 1'b0;
      end
    end
    chk("rr_count", got, 2);
    if (got == 2) begin
      chk("rr_src0", {62'd0, got_src[0]}, 64'd0);
      chk("rr_data0", got_data[0], 64'h11);
      chk("rr_src1", {62'd0, got_src[1]}, 64'd3);
      chk("rr_data1", got_data[1], 64'h33);
    end
    timed_out = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.nicEn != 4'b0000 && bus.nic_addr == 2'b01) begin
        timed_out = 1'b0;
        chk("rr_wrap", {60'd0, bus.nicEn}, 64'h1);
        break;
      end
    end
    chk("wrap_timeout", {63'd0, timed_out}, 64'd0);

    // RX backpressure on NIC2
    in_data[2]   = 64'h2222_3333_4444_5555;
    bus.rx_ready = 1'b0;
    in_full[2]   = 1'b1;
    timed_out    = 1'b1;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (bus.rx_valid) begin
        timed_out = 1'b0;
        break;
      end
    end
    chk("bp_timeout", {63'd0, timed_out}, 64'd0);
    in_full[2] = 1'b0;
    for (int c = 0; c < 5; c++) begin
      chk("bp_rxv", {63'd0, bus.rx_valid}, 64'd1);
      chk("bp_data", bus.rx_data, 64'h2222_3333_4444_5555);
      chk("bp_src", {62'd0, bus.rx_src}, 64'd2);
      chk("bp_nicEn", {60'd0, bus.nicEn}, 64'd0);
      @(negedge clk);
    end
    bus.rx_ready = 1'b1;
    @(negedge clk);
    chk("bp_release", {63'd0, bus.rx_valid}, 64'd0);

    // Contention: TX and RX services must alternate
    for (int i = 0; i < 4; i++) in_data[i] = 64'h100 + 64'(i);
    in_full      = 4'b1111;
    bus.tx_dest  = 2'd0;
    bus.tx_data  = 64'h0C0C_0C0C;
    bus.tx_valid = 1'b1;
    have_prev    = 1'b0;
    prev_svc     = 1'b0;
    n_tx         = 0;
    n_rx         = 0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (bus.tx_ready || (bus.rx_valid && bus.rx_ready)) begin
        svc = bus.tx_ready;
        if (svc) n_tx++;
        else n_rx++;
        if (have_prev) chk("alternate", {63'd0, svc}, {63'd0, ~prev_svc});
        prev_svc  = svc;
        have_prev = 1'b1;
      end
    end
    chk("mix_tx", {63'd0, (n_tx >= 5)}, 64'd1);
    chk("mix_rx", {63'd0, (n_rx >= 5)}, 64'd1);
    bus.tx_valid = 1'b0;
    in_full      = 4'b0000;
    repeat (8) @(negedge clk);

    // Reset while a packet is waiting in RX_OUT
    in_data[1]   = 64'h77;
    bus.rx_ready = 1'b0;
    in_full[1]   = 1'b1;
    timed_out    = 1'b1;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (bus.rx_valid) begin
        timed_out = 1'b0;
        break;
      end
    end
    chk("rxo_timeout", {63'd0, timed_out}, 64'd0);
    chk("rxo_src", {62'd0, bus.rx_src}, 64'd1);
    in_full[1] = 1'b0;
    reset      = 1'b1;
    #1;
    chk_reset_outputs("rst_rxo");
    @(negedge clk);
    @(negedge clk);
    bus.rx_ready = 1'b1;
    reset        = 1'b0;
    n_rxv        = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.rx_valid) n_rxv++;
    end
    chk("rxo_no_replay", n_rxv, 0);

    // Reset while in TX_CHK: no write may follow
    reset        = 1'b1;
    bus.tx_dest  = 2'd3;
    bus.tx_data  = 64'hDEAD_BEEF;
    bus.tx_valid = 1'b1;
    @(negedge clk);
    reset     = 1'b0;
    wr_before = wr_cnt[3];
    timed_out = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.nicEn == 4'b1000 && bus.nic_addr == 2'b11) begin
        timed_out = 1'b0;
        break;
      end
    end
    chk("txc_timeout", {63'd0, timed_out}, 64'd0);
    reset = 1'b1;
    #1;
    chk_reset_outputs("rst_txc");
    bus.tx_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    chk("txc_no_write", wr_cnt[3] - wr_before, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
